axis_frame_source: RTL and testbench
====================================

Name: axis_frame_source

Overview:
- AXI4-Stream master that feeds the team's AXI_stream_slave stage.
- Accepts raw pixel words from an upstream valid/ready pixel port and packetises one frame per start command.
- Frame geometry: LINES_PER_FRAME lines of LINE_LEN pixels.
- Drives tuser on the first pixel of the frame and tlast on the last pixel of every line.
- Contains a 2-entry skid buffer so that upstream ready is registered and full throughput is sustained under backpressure.

Parameters:
DATA_WIDTH, 32, width of pixel word and m_axis_tdata
LINE_LEN, 8, pixels per line (>=2)
LINES_PER_FRAME, 4, lines per frame (>=1)

Ports:
clk  input  1  single clock, all logic rising-edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse: begin a new frame (ignored unless IDLE)
pixel_data  input  DATA_WIDTH  upstream pixel word
pixel_valid  input  1  upstream word valid
pixel_ready  output  1  block accepts pixel_data this cycle (registered)
m_axis_tdata  output  DATA_WIDTH  stream data
m_axis_tvalid  output  1  stream valid
m_axis_tready  input  1  downstream ready
m_axis_tlast  output  1  end of line
m_axis_tuser  output  1  start of frame
busy  output  1  high from the start-accept cycle until frame_done
frame_done  output  1  one-cycle pulse after the last beat of the frame is transferred

Behaviour:
- Reset (asynchronous, active-high; may be asserted at any time, including mid-frame):
  - All outputs go to 0 immediately: pixel_ready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, busy, frame_done.
  - Counters and skid entries are cleared; FSM goes to IDLE.
  - In-flight beats are discarded; no partial frame resumes after reset.
- FSM states:
  - IDLE:
    - pixel_ready=0, busy=0.
    - start=1 -> ACCEPT next cycle.
    - col_cnt=0, row_cnt=0.
  - ACCEPT:
    - busy=1.
    - Input handshake = pixel_valid & pixel_ready.
    - On each handshake, push {pixel_data, tuser=(col==0 & row==0), tlast=(col==LINE_LEN-1)} into the skid buffer.
    - col increments; it wraps to 0 at LINE_LEN-1, and row increments on that wrap.
    - Handshake on the final pixel (col=LINE_LEN-1, row=LINES_PER_FRAME-1) -> DRAIN.
    - pixel_ready is deasserted from the next cycle.
  - DRAIN:
    - pixel_ready=0, busy=1.
    - When the buffer is empty and no beat is pending -> DONE.
  - DONE:
    - frame_done=1 for exactly one cycle, busy=1.
    - -> IDLE.
- start in any state other than IDLE is ignored.
- start in the DONE cycle is ignored; a new frame needs start while in IDLE.
- Skid buffer (2 entries, head drives m_axis_*):
  - pixel_ready (registered) = state==ACCEPT & entries_next<2 & not final-pixel-accepted.
  - Output handshake = m_axis_tvalid & m_axis_tready; it pops the head.
  - Simultaneous push and pop keeps the count unchanged; order is preserved.
  - Latency: pixel accepted at edge N appears on m_axis_* after edge N when the buffer is empty (1 cycle).
  - Steady state with tready=1: 1 beat/cycle.
- AXI rules:
  - Once m_axis_tvalid=1, tdata/tlast/tuser are held stable until the handshake.
  - tvalid never deasserts without a handshake, except on rst.
  - tvalid does not depend combinationally on tready.
- Counter widths: $clog2(LINE_LEN) and $clog2(LINES_PER_FRAME), minimum 1 bit.
- tuser is asserted on exactly one beat per frame; tlast on exactly LINES_PER_FRAME beats.
- Upstream stall (pixel_valid=0) in ACCEPT:
  - Counters hold.
  - The buffer continues draining; tvalid drops when it is empty.

Test Plan:
1. Reset, start pulse, pixel_valid=1 with data 0..31 incrementing, tready=1 -> 32 beats on consecutive cycles, data 0..31. tuser only on data 0. tlast on data 7, 15, 23, 31. frame_done pulse one cycle after beat 31. busy then low.
2. Same stimulus, tready toggling 1/0 every cycle -> same 32-beat sequence with no loss or duplication. tdata/tlast/tuser held stable during every tready=0 cycle. pixel_ready drops when 2 entries are held.
3. tready=0 for 10 cycles at frame start -> exactly 2 pixels accepted (0, 1). pixel_ready=0 afterwards. On tready=1, beats 0 and 1 emerge back-to-back, then the stream resumes.
4. start asserted mid-frame (after 5 beats) and in the DONE cycle -> ignored; the frame completes with exactly 32 beats. A second start in IDLE produces a second frame whose first beat carries tuser=1.
5. rst asserted after 12 beats with tvalid=1 and tready=0 -> tvalid, pixel_ready, and busy go 0 asynchronously. After release and a new start, the next frame starts with tuser=1 on its first pixel and outputs 32 beats.
6. pixel_valid gaps (valid 1 cycle out of 3) -> tlast/tuser positions are unchanged (beats 7, 15, 23, 31 / beat 0). frame_done fires once.

Source files
------------

// File: rtl/axis_frame_source.sv
// AXI4-Stream frame source: packetises upstream pixel words into one frame
// (LINES_PER_FRAME lines of LINE_LEN pixels) per start command, marking
// start-of-frame on tuser and end-of-line on tlast. A 2-entry skid buffer
// keeps pixel_ready registered while sustaining one beat per cycle.
module axis_frame_source #(
  parameter int DATA_WIDTH      = 32,
  parameter int LINE_LEN        = 8,
  parameter int LINES_PER_FRAME = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] pixel_data,
  input  logic                  pixel_valid,
  output logic                  pixel_ready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int CW = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam int RW = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCEPT,
    DRAIN,
    DONE
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [1:0]            count;
  logic [1:0]            count_nxt;
  // skid entries hold {data, tuser, tlast}; ent0 is the head
  logic [DATA_WIDTH+1:0] ent0;
  logic [DATA_WIDTH+1:0] ent1;
  logic [DATA_WIDTH+1:0] new_beat;
  logic                  push;
  logic                  pop;
  logic                  col_last;
  logic                  is_final;

  assign push     = pixel_valid & pixel_ready;
  assign pop      = m_axis_tvalid & m_axis_tready;
  assign col_last = (col == CW'(LINE_LEN - 1));
  assign is_final = col_last && (row == RW'(LINES_PER_FRAME - 1));
  assign new_beat = {pixel_data, (col == '0) && (row == '0), col_last};

  assign m_axis_tvalid = (count != 2'd0);
  assign m_axis_tdata  = ent0[DATA_WIDTH+1:2];
  assign m_axis_tuser  = ent0[1];
  assign m_axis_tlast  = ent0[0];

  // Next occupancy and next FSM state
  always_comb begin
    count_nxt = count + 2'(push) - 2'(pop);
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACCEPT;
      ACCEPT:  if (push && is_final) state_nxt = DRAIN;
      DRAIN:   if (count_nxt == 2'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM, counters, skid buffer and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      col         <= '0;
      row         <= '0;
      count       <= '0;
      ent0        <= '0;
      ent1        <= '0;
      pixel_ready <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state      <= state_nxt;
      busy       <= (state_nxt != IDLE);
      frame_done <= (state_nxt == DONE);
      // final-pixel acceptance moves to DRAIN, which already drops ready
      pixel_ready <= (state_nxt == ACCEPT) && (count_nxt < 2'd2);
      count      <= count_nxt;

      if (state == IDLE) begin
        col <= '0;
        row <= '0;
      end else if (push) begin
        if (col_last) begin
          col <= '0;
          row <= row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end

      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) ent0 <= new_beat;
          else               ent1 <= new_beat;
        end
        2'b01: ent0 <= ent1;
        2'b11: begin
          if (count == 2'd1) begin
            ent0 <= new_beat;
          end else begin
            ent0 <= ent1;
            ent1 <= new_beat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_frame_source.sv
// Self-checking bench for axis_frame_source: scoreboard of expected beats
// filled on input handshakes, drained and compared on output handshakes.
module tb_axis_frame_source;

  localparam int DW  = 32;
  localparam int LL  = 8;
  localparam int LPF = 4;
  localparam int NB  = LL * LPF;

  typedef logic [DW+1:0] beat_t;  // {data, tuser, tlast}

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] pixel_data;
  logic          pixel_valid;
  logic          pixel_ready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          m_axis_tuser;
  logic          busy;
  logic          frame_done;

  always #5 clk = ~clk;

  axis_frame_source #(
    .DATA_WIDTH     (DW),
    .LINE_LEN       (LL),
    .LINES_PER_FRAME(LPF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .pixel_data   (pixel_data),
    .pixel_valid  (pixel_valid),
    .pixel_ready  (pixel_ready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tuser (m_axis_tuser),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  beat_t sb[$];
  int    vectors = 0;
  int    errors  = 0;
  int    next_pix;
  int    fidx;
  int    cyc = 0;

  // observations of the cycle handled by the latest tick
  logic  o_valid, o_ready, o_busy, o_done, in_hs, out_hs;
  beat_t o_beat, o_exp;
  int    o_qsize;

  task automatic new_frame();
    sb.delete();
    next_pix = 0;
    fidx     = 0;
  endtask

  // Drive one cycle of inputs (called at a negedge), sample outputs,
  // update the scoreboard for the handshakes at the coming posedge.
  task automatic tick(input logic tr, input logic pv, input logic st);
    m_axis_tready = tr;
    pixel_valid   = pv;
    start         = st;
    pixel_data    = DW'(next_pix);
    o_valid = m_axis_tvalid;
    o_ready = pixel_ready;
    o_busy  = busy;
    o_done  = frame_done;
    o_beat  = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
    o_qsize = sb.size();
    in_hs   = pv & o_ready;
    out_hs  = o_valid & tr;
    o_exp   = 'x;
    if (out_hs && sb.size() > 0) o_exp = sb.pop_front();
    if (in_hs) begin
      sb.push_back({DW'(next_pix), fidx == 0, (fidx % LL) == LL - 1});
      next_pix++;
      fidx++;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [DW+5:0] obs;
    rst = 1'b1; start = 1'b0; pixel_valid = 1'b0; m_axis_tready = 1'b0;
    pixel_data = '0;
    repeat (3) @(negedge clk);
    obs = {pixel_ready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, busy, frame_done};
    vectors++;
    if (obs !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", obs);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy, pixel_ready, m_axis_tvalid} !== 3'b000) begin
      errors++; $display("FAIL idle_after_reset: got %b expected 000", {busy, pixel_ready, m_axis_tvalid});
    end
  endtask

  task automatic test_full_rate();
    int beats = 0, first_cyc = -1, last_cyc = -1, done_cyc = -1;
    new_frame();
    tick(1'b1, 1'b1, 1'b1);
    for (int n = 0; n < 300 && done_cyc < 0; n++) begin
      tick(1'b1, 1'b1, 1'b0);
      if (out_hs) begin
        vectors++;
        if (o_beat !== o_exp) begin
          errors++; $display("FAIL full_rate_beat%0d: got %h expected %h", beats, o_beat, o_exp);
        end
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        beats++;
      end
      if (o_done) done_cyc = cyc;
    end
    vectors++;
    if (beats !== NB || done_cyc < 0) begin
      errors++; $display("FAIL full_rate_count: got %0d beats (done=%0d) expected %0d", beats, done_cyc, NB);
    end
    vectors++;
    if (last_cyc - first_cyc !== NB - 1) begin
      errors++; $display("FAIL full_rate_throughput: got span %0d expected %0d", last_cyc - first_cyc, NB - 1);
    end
    vectors++;
    if (done_cyc !== last_cyc + 1) begin
      errors++; $display("FAIL done_timing: got cycle %0d expected %0d", done_cyc, last_cyc + 1);
    end
    tick(1'b1, 1'b1, 1'b0);
    vectors++;
    if ({o_busy, o_done, o_valid} !== 3'b000) begin
      errors++; $display("FAIL busy_after_done: got %b expected 000", {o_busy, o_done, o_valid});
    end
  endtask

  task automatic test_toggle_ready();
    int    beats = 0;
    logic  done = 1'b0, full_seen = 1'b0, prev_stall = 1'b0;
    beat_t prev_beat = '0;
    new_frame();
    tick(1'b1, 1'b1, 1'b1);
    for (int n = 0; n < 400 && !done; n++) begin
      tick(n % 2 == 0, 1'b1, 1'b0);
      if (prev_stall) begin
        vectors++;
        if ({o_valid, o_beat} !== {1'b1, prev_beat}) begin
          errors++; $display("FAIL toggle_hold: got %b/%h expected 1/%h", o_valid, o_beat, prev_beat);
        end
      end
      if (o_qsize == 2) begin
        full_seen = 1'b1;
        vectors++;
        if (o_ready !== 1'b0) begin
          errors++; $display("FAIL toggle_ready_full: got %b expected 0", o_ready);
        end
      end
      if (out_hs) begin
        vectors++;
        if (o_beat !== o_exp) begin
          errors++; $display("FAIL toggle_beat%0d: got %h expected %h", beats, o_beat, o_exp);
        end
        beats++;
      end
      prev_stall = o_valid & (n % 2 != 0);
      prev_beat  = o_beat;
      if (o_done) done = 1'b1;
    end
    vectors++;
    if (beats !== NB || !done || full_seen !== 1'b1) begin
      errors++; $display("FAIL toggle_count: got %0d beats done=%b full=%b expected %0d 1 1", beats, done, full_seen, NB);
    end
  endtask

  task automatic test_stall_start();
    int   beats = 0, acc = 0, c0 = 0, c1 = 0;
    logic done = 1'b0;
    new_frame();
    tick(1'b0, 1'b1, 1'b1);
    repeat (9) begin
      tick(1'b0, 1'b1, 1'b0);
      if (in_hs) acc++;
    end
    vectors++;
    if (acc !== 2 || pixel_ready !== 1'b0 || m_axis_tvalid !== 1'b1) begin
      errors++; $display("FAIL stall_accept: got acc=%0d ready=%b valid=%b expected 2 0 1", acc, pixel_ready, m_axis_tvalid);
    end
    for (int n = 0; n < 300 && !done; n++) begin
      tick(1'b1, 1'b1, 1'b0);
      if (out_hs) begin
        vectors++;
        if (o_beat !== o_exp) begin
          errors++; $display("FAIL stall_beat%0d: got %h expected %h", beats, o_beat, o_exp);
        end
        if (beats == 0) c0 = cyc;
        if (beats == 1) c1 = cyc;
        beats++;
      end
      if (o_done) done = 1'b1;
    end
    vectors++;
    if (beats !== NB || !done || c1 !== c0 + 1) begin
      errors++; $display("FAIL stall_resume: got %0d beats gap=%0d expected %0d gap 1", beats, c1 - c0, NB);
    end
  endtask

  task automatic test_start_ignored();
    int   beats = 0;
    logic done = 1'b0, mid_sent = 1'b0, st;
    new_frame();
    tick(1'b1, 1'b1, 1'b1);
    for (int n = 0; n < 300 && !done; n++) begin
      st = frame_done;
      if (beats == 5 && !mid_sent) begin st = 1'b1; mid_sent = 1'b1; end
      tick(1'b1, 1'b1, st);
      if (out_hs) begin
        vectors++;
        if (o_beat !== o_exp) begin
          errors++; $display("FAIL ignore_beat%0d: got %h expected %h", beats, o_beat, o_exp);
        end
        beats++;
      end
      if (o_done) done = 1'b1;
    end
    repeat (5) begin
      tick(1'b1, 1'b1, 1'b0);
      vectors++;
      if ({o_busy, o_valid, o_ready} !== 3'b000) begin
        errors++; $display("FAIL ignore_idle: got %b expected 000", {o_busy, o_valid, o_ready});
      end
    end
    vectors++;
    if (beats !== NB || !done) begin
      errors++; $display("FAIL ignore_count: got %0d beats expected %0d", beats, NB);
    end
    new_frame();
    beats = 0; done = 1'b0;
    tick(1'b1, 1'b1, 1'b1);
    for (int n = 0; n < 300 && !done; n++) begin
      tick(1'b1, 1'b1, 1'b0);
      if (out_hs) begin
        vectors++;
        if (o_beat !== o_exp || (beats == 0 && o_beat[1] !== 1'b1)) begin
          errors++; $display("FAIL second_frame_beat%0d: got %h expected %h", beats, o_beat, o_exp);
        end
        beats++;
      end
      if (o_done) done = 1'b1;
    end
    vectors++;
    if (beats !== NB || !done) begin
      errors++; $display("FAIL second_frame_count: got %0d beats expected %0d", beats, NB);
    end
  endtask

  task automatic test_reset_midframe();
    int            beats = 0;
    logic          done = 1'b0;
    logic [DW+5:0] obs;
    new_frame();
    tick(1'b1, 1'b1, 1'b1);
    for (int n = 0; n < 100 && beats < 12; n++) begin
      tick(1'b1, 1'b1, 1'b0);
      if (out_hs) begin
        vectors++;
        if (o_beat !== o_exp) begin
          errors++; $display("FAIL pre_reset_beat%0d: got %h expected %h", beats, o_beat, o_exp);
        end
        beats++;
      end
    end
    tick(1'b0, 1'b1, 1'b0);
    vectors++;
    if (m_axis_tvalid !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL pre_reset_state: got valid=%b busy=%b expected 1 1", m_axis_tvalid, busy);
    end
    #2 rst = 1'b1;
    #1;
    obs = {pixel_ready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, busy, frame_done};
    vectors++;
    if (obs !== '0) begin
      errors++; $display("FAIL async_reset: got %h expected 0", obs);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    new_frame();
    beats = 0;
    tick(1'b1, 1'b1, 1'b1);
    for (int n = 0; n < 300 && !done; n++) begin
      tick(1'b1, 1'b1, 1'b0);
      if (out_hs) begin
        vectors++;
        if (o_beat !== o_exp || (beats == 0 && o_beat[1] !== 1'b1)) begin
          errors++; $display("FAIL post_reset_beat%0d: got %h expected %h", beats, o_beat, o_exp);
        end
        beats++;
      end
      if (o_done) done = 1'b1;
    end
    vectors++;
    if (beats !== NB || !done) begin
      errors++; $display("FAIL post_reset_count: got %0d beats expected %0d", beats, NB);
    end
  endtask

  task automatic test_valid_gaps();
    int beats = 0, dones = 0, lasts = 0, users = 0;
    new_frame();
    tick(1'b1, 1'b0, 1'b1);
    for (int n = 0; n < 500 && (dones == 0 || n < 150); n++) begin
      tick(1'b1, n % 3 == 0, 1'b0);
      if (out_hs) begin
        vectors++;
        if (o_beat !== o_exp) begin
          errors++; $display("FAIL gaps_beat%0d: got %h expected %h", beats, o_beat, o_exp);
        end
        if (o_beat[0]) lasts++;
        if (o_beat[1]) users++;
        beats++;
      end
      if (o_done) dones++;
    end
    vectors++;
    if (beats !== NB || dones !== 1 || lasts !== LPF || users !== 1) begin
      errors++; $display("FAIL gaps_summary: got beats=%0d dones=%0d tlast=%0d tuser=%0d expected %0d 1 %0d 1",
                         beats, dones, lasts, users, NB, LPF);
    end
  endtask

  initial begin
    test_reset();
    test_full_rate();
    test_toggle_ready();
    test_stall_start();
    test_start_ignored();
    test_reset_midframe();
    test_valid_gaps();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
